pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the PC and instruction-address width in bits.
REQ-002 Parameter INSTR_W, default 32, SHALL set the instruction width in bits.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  fetch enable
- imem_req  out  1  instruction-memory request
- imem_addr  out  ADDR_W  request address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  INSTR_W  read data
- if_valid  out  1  fetched instruction valid
- if_pc  out  ADDR_W  PC of the fetched instruction
- if_instr  out  INSTR_W  fetched instruction
- if_ready  in  1  downstream accepts
- redirect_valid  in  1  branch or jump redirect
- redirect_pc  in  ADDR_W  redirect target
- misalign_err  out  1  sticky misaligned-redirect flag

Function
REQ-006 The FSM SHALL have exactly the states IDLE, REQ, WAIT, HOLD and DROP.
REQ-007 In IDLE, en=1 SHALL move the FSM to REQ on the next edge; en=0 SHALL keep it in IDLE.
REQ-008 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL stay stable until imem_gnt=1, and imem_gnt=1 SHALL move the FSM to WAIT.
REQ-009 In WAIT, imem_rvalid=1 SHALL:
- capture imem_rdata into if_instr;
- set if_pc to pc and if_valid to 1;
- advance pc to pc+4;
- move the FSM to HOLD.
REQ-010 In HOLD, if_valid, if_pc and if_instr SHALL hold until if_ready=1; the FSM SHALL then go to REQ if en=1, else to IDLE, with if_valid cleared.
REQ-011 Best-case latency SHALL be 3 cycles: en sampled in IDLE at edge 0, imem_gnt in the first REQ cycle, imem_rvalid in the first WAIT cycle, and if_valid high after edge 3.
REQ-012 pc arithmetic SHALL wrap modulo 2^ADDR_W, so pc = 2^ADDR_W-4 advances to 0.
REQ-013 redirect_valid SHALL have priority over every other event: on that edge pc loads redirect_pc and if_valid clears.
REQ-014 After a redirect, the next state SHALL be:
- DROP if sampled in WAIT without imem_rvalid;
- REQ if en=1 in any other state;
- IDLE if en=0 in any other state.
REQ-015 If redirect and imem_rvalid coincide in WAIT, the response SHALL be discarded and the FSM SHALL go to REQ (or IDLE if en=0).
REQ-016 DROP SHALL assert no request, SHALL discard the next imem_rvalid, and SHALL then go to REQ (or IDLE if en=0).
REQ-017 If redirect and if_ready coincide in HOLD, the held instruction SHALL count as consumed and pc SHALL take redirect_pc.
REQ-018 en falling mid-fetch SHALL NOT abort the fetch; the FSM SHALL finish the fetch and the HOLD handshake, then go to IDLE.
REQ-019 imem_req SHALL be 0 in every state other than REQ.

Reset
REQ-020 Asserting rst SHALL immediately set pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0 and misalign_err=0.
REQ-021 Reset asserted mid-fetch SHALL abandon the fetch, and any imem_rvalid arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-022 With macro PC_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL be ignored (pc, state and outputs unchanged) and SHALL set misalign_err, which stays set until rst.
REQ-023 Without PC_ALIGN_CHECK_EN, misalign_err SHALL be tied to 0 and redirect_pc SHALL be used unmodified.

Verification
REQ-024 The bench SHALL cover, with imem_gnt and imem_rvalid each returned 1 cycle after request:
- Reset, en=1: imem_addr sequence 0x0, 0x4, 0x8; if_instr matches memory; first if_valid 3 cycles after en.
- if_ready held 0 for 5 cycles in HOLD: if_valid, if_pc and if_instr stable, and no new imem_req.
- Redirect to 0x100 during WAIT (no rvalid): FSM enters DROP, stale data never reaches if_valid, next imem_addr=0x100.
- RESET_PC=0xFFFFFFFC: after the first fetch, the next imem_addr=0x0.
- PC_ALIGN_CHECK_EN defined, redirect_pc=0x102: misalign_err=1, next imem_addr unchanged (pc+4 sequence).
- rst asserted in WAIT, then a late imem_rvalid: if_valid stays 0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch unit: walks a PC through a req/gnt/rvalid instruction memory
// and hands each fetched word downstream with a valid/ready handshake.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned redirects and flags misalign_err.
module pc_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               misalign_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic                valid_reg, valid_next;
    logic [ADDR_W-1:0]   if_pc_reg, if_pc_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic                redirect_bad;
    logic                redirect_take;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = misalign_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (redirect_bad) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    assign redirect_bad = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // A rejected (misaligned) redirect behaves as if no redirect was seen at all.
    assign redirect_take = redirect_valid && !redirect_bad;

    assign imem_req  = (state_reg == REQ);
    assign imem_addr = pc_reg;
    assign if_valid  = valid_reg;
    assign if_pc     = if_pc_reg;
    assign if_instr  = instr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            if_pc_reg <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            if_pc_reg <= if_pc_next;
            instr_reg <= instr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        if_pc_next = if_pc_reg;
        instr_next = instr_reg;

        if (redirect_take) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            // A granted request with no response yet must have that response swallowed.
            if (state_reg == WAIT && !imem_rvalid) begin
                state_next = DROP;
            end else begin
                state_next = en ? REQ : IDLE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_next = REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_next = imem_rdata;
                        if_pc_next = pc_reg;
                        valid_next = 1'b1;
                        pc_next    = pc_reg + ADDR_W'(4);
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        valid_next = 1'b0;
                        state_next = en ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_next = en ? REQ : IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a small instruction-memory responder plus queues of
// expected request addresses and expected fetched PCs checked as the DUT produces them.
module tb_pc_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, imem_gnt, imem_rvalid, if_ready, redirect_valid;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, if_valid, misalign_err;
    logic [31:0] imem_addr, if_pc, if_instr;
    logic        w_imem_req, w_if_valid, w_misalign_err;
    logic [31:0] w_imem_addr, w_if_pc, w_if_instr;

    pc_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    // Second instance in lockstep, only its reset PC differs (wrap-around check).
    pc_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr), .if_ready(if_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(w_misalign_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] addr_q[$];
    logic [31:0] pc_q[$];
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          rv_delay;
    bit          accepted;
    logic        prev_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update responder/scoreboard after it.
    task automatic tick();
        bit          acc;
        bit          fire;
        logic [31:0] acc_addr;
        logic [31:0] e;
        acc      = imem_req && imem_gnt;
        acc_addr = imem_addr;
        fire     = imem_rvalid;
        @(posedge clk);
        #1;
        accepted = acc;
        if (acc) begin
            if (addr_q.size() == 0) begin
                check("unexpected_req", {31'd0, acc}, 64'd0);
            end else begin
                e = addr_q.pop_front();
                check("req_addr", acc_addr, e);
            end
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = rv_delay;
        end else if (pend && fire) begin
            pend = 1'b0;
        end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
        end
        if (if_valid && !prev_valid) begin
            if (pc_q.size() == 0) begin
                check("unexpected_valid", {63'd0, if_valid}, 64'd0);
            end else begin
                e = pc_q.pop_front();
                check("if_pc", if_pc, e);
                check("if_instr", if_instr, mem_word(e));
            end
        end
        prev_valid  = if_valid;
        imem_gnt    = imem_req;
        imem_rvalid = pend && (pend_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'd0;
    endtask

    // Run until all queued fetches are delivered, then stop fetching after the handshake.
    task automatic drain(input string tag);
        int c;
        c = 0;
        while (pc_q.size() != 0 && c < 60) begin
            tick();
            c++;
        end
        check({tag, "_fetch_done"}, pc_q.size(), 0);
        en = 1'b0;
        tick();
        check({tag, "_addr_q_empty"}, addr_q.size(), 0);
        check({tag, "_idle_valid"}, {63'd0, if_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          c;
        logic        exp_mis;
        logic [31:0] exp_pc;

        rst = 1'b0; en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0; rv_delay = 0; prev_valid = 1'b0;
        accepted = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_req", {63'd0, imem_req}, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {63'd0, if_valid}, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        check("rst_misalign", {63'd0, misalign_err}, 0);
        check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        rst = 1'b0;

        // Straight-line fetch 0x0, 0x4, 0x8 with best-case memory timing.
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        pc_q.push_back(32'h0);   pc_q.push_back(32'h4);   pc_q.push_back(32'h8);
        en  = 1'b1;
        lat = 0;
        while (!if_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("first_valid_latency", lat, 3);
        tick();
        check("wrap_req", {63'd0, w_imem_req}, 1);
        check("wrap_addr", w_imem_addr, 32'h0);
        check("second_addr", imem_addr, 32'h4);
        drain("seq");

        // Downstream stall: output must hold with no new request.
        if_ready = 1'b0;
        addr_q.push_back(32'hC);
        pc_q.push_back(32'hC);
        en = 1'b1;
        c  = 0;
        while (!if_valid && c < 10) begin
            tick();
            c++;
        end
        check("stall_valid_up", {63'd0, if_valid}, 1);
        repeat (5) begin
            tick();
            check("stall_valid", {63'd0, if_valid}, 1);
            check("stall_pc", if_pc, 32'hC);
            check("stall_instr", if_instr, mem_word(32'hC));
            check("stall_req", {63'd0, imem_req}, 0);
        end
        if_ready = 1'b1;
        en       = 1'b0;
        tick();
        check("stall_release_valid", {63'd0, if_valid}, 0);
        check("stall_release_req", {63'd0, imem_req}, 0);

        // Redirect while waiting for a late response: the stale word must be dropped.
        rv_delay = 1;
        addr_q.push_back(32'h10);
        en = 1'b1;
        c  = 0;
        accepted = 1'b0;
        while (!accepted && c < 10) begin
            tick();
            c++;
        end
        check("redir_accepted", {63'd0, accepted}, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        addr_q.push_back(32'h100);
        pc_q.push_back(32'h100);
        rv_delay = 0;
        tick();
        redirect_valid = 1'b0;
        check("drop_req", {63'd0, imem_req}, 0);
        check("drop_addr", imem_addr, 32'h100);
        check("drop_valid", {63'd0, if_valid}, 0);
        tick();
        check("after_drop_req", {63'd0, imem_req}, 1);
        check("after_drop_addr", imem_addr, 32'h100);
        check("after_drop_valid", {63'd0, if_valid}, 0);
        drain("redir");

        // Misaligned redirect in IDLE.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        exp_mis = 1'b1;
        exp_pc  = 32'h104;
`else
        exp_mis = 1'b0;
        exp_pc  = 32'h102;
`endif
        check("misalign_flag", {63'd0, misalign_err}, {63'd0, exp_mis});
        check("misalign_pc", imem_addr, exp_pc);
        addr_q.push_back(exp_pc);
        pc_q.push_back(exp_pc);
        en = 1'b1;
        drain("misalign");
        check("misalign_sticky", {63'd0, misalign_err}, {63'd0, exp_mis});

        // Reset during WAIT, then the abandoned response shows up while IDLE.
        rv_delay = 2;
        addr_q.push_back(exp_pc + 32'd4);
        en = 1'b1;
        c  = 0;
        accepted = 1'b0;
        while (!accepted && c < 10) begin
            tick();
            c++;
        end
        check("rstmid_accepted", {63'd0, accepted}, 1);
        rst = 1'b1;
        #1;
        check("rstmid_req", {63'd0, imem_req}, 0);
        check("rstmid_addr", imem_addr, 32'h0);
        check("rstmid_valid", {63'd0, if_valid}, 0);
        check("rstmid_misalign", {63'd0, misalign_err}, 0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("late_rvalid_valid", {63'd0, if_valid}, 0);
            check("late_rvalid_addr", imem_addr, 32'h0);
            check("late_rvalid_req", {63'd0, imem_req}, 0);
        end
        check("end_addr_q", addr_q.size(), 0);
        check("end_pc_q", pc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
